// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : Shared types and constants for the bit-serial subtractor
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // Default operand/result width
    localparam int c_default_n = 8;

    // Controller states; encodings are fixed so they stay stable across builds
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/fs_cell.sv
`default_nettype none
// ============================================================================
// Module   : fs_cell
// Brief    : Combinational one-bit full subtractor (difference and borrow)
// Revision : 1.0 - initial release
// ============================================================================
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic borrow
);

    // Difference bit of x - y - c
    assign d      = x ^ y ^ c;
    // Borrow out: x smaller than y, or equal bits with a pending borrow
    assign borrow = (~x & y) | (~(x ^ y) & c);

endmodule : fs_cell
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Brief    : Bit-serial N-bit subtractor (a - b - bin), LSB first, one bit per
//            clock through a single shared full-subtractor cell, with a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = c_default_n
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int             c_cw       = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(N - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_last;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_d;
    logic            r_br;
    logic [c_cw-1:0] r_cnt;
    logic [N-1:0]    r_diff;
    logic            r_bout;

    logic            w_cell_d;
    logic            w_cell_borrow;

    // The single shared cell sees the current LSBs and the carried borrow
    fs_cell u_fs_cell (
        .x      (r_a[0]),
        .y      (r_b[0]),
        .c      (r_br),
        .d      (w_cell_d),
        .borrow (w_cell_borrow)
    );

    // Final bit of an operation is being processed on this edge
    assign w_last = (r_state == ST_RUN) && (r_cnt == c_cnt_last);

    // Next-state logic; start is honoured only in IDLE and DONE
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, operand shifters, counter, borrow flop and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_br  <= bin;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_a   <= {1'b0, r_a[N-1:1]};
                r_b   <= {1'b0, r_b[N-1:1]};
                r_d   <= {w_cell_d, r_d[N-1:1]};
                r_br  <= w_cell_borrow;
                r_cnt <= r_cnt + c_cw'(1);
                if (w_last) begin
                    r_diff <= {w_cell_d, r_d[N-1:1]};
                    r_bout <= w_cell_borrow;
                end
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule : serial_sub
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Brief    : Directed self-checking bench for serial_sub (N=8 and N=4 sweep)
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;

    int n_assert = 0;
    int n_fail   = 0;

    // 10-unit clock
    always #5 clk = ~clk;

    serial_sub #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    serial_sub #(.N(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge after an accepting edge; returns cycles until done
    task automatic wait_done8(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            step();
            cyc++;
        end
    endtask

    // One complete N=8 operation starting at a negedge
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                       input logic [7:0] ed, input logic eb, input string tag);
        int cyc;
        int bcnt;
        a = av; b = bv; bin = bv_in; start = 1'b1;
        step();
        start = 1'b0;
        wait_done8(cyc, bcnt);
        chk({tag, "_latency"}, cyc, 8);
        chk({tag, "_busy_cycles"}, bcnt, 8);
        chk({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        step();
        chk({tag, "_done_pulse"}, {31'd0, done}, 0);
        chk({tag, "_diff_hold"}, {24'd0, diff}, {24'd0, ed});
    endtask

    initial begin
        int  cyc;
        int  bcnt;
        int  ex;
        bit  seen;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_diff", {24'd0, diff}, 0);
        chk("rst_bout", {31'd0, bout}, 0);

        // Basic arithmetic and wrap cases
        op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "t5a_3c");
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t00_01");
        op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, "t80_7f_b");
        op8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "t00_ff_b");

        // Start during RUN is ignored
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        wait_done8(cyc, bcnt);
        chk("ign_latency", cyc, 5);
        chk("ign_diff", {24'd0, diff}, 32'h0F);
        chk("ign_bout", {31'd0, bout}, 0);

        // Back-to-back: start held in the DONE cycle
        a = 8'h03; b = 8'h05; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 1);
        chk("b2b_done", {31'd0, done}, 0);
        chk("b2b_prev_diff_hold", {24'd0, diff}, 32'h0F);
        wait_done8(cyc, bcnt);
        chk("b2b_latency", cyc, 8);
        chk("b2b_busy_cycles", bcnt, 8);
        chk("b2b_diff", {24'd0, diff}, 32'hFE);
        chk("b2b_bout", {31'd0, bout}, 1);
        step();

        // Reset in the middle of RUN
        a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("mid_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 0);
        chk("mrst_done", {31'd0, done}, 0);
        chk("mrst_diff", {24'd0, diff}, 0);
        chk("mrst_bout", {31'd0, bout}, 0);
        seen = 1'b0;
        repeat (12) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        chk("mrst_no_done", {31'd0, seen}, 0);
        op8(8'hC3, 8'h42, 1'b1, 8'h80, 1'b0, "post_rst");

        // Exhaustive N=4 sweep, chained back-to-back through the DONE cycle
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    cyc = 0;
                    while (done4 !== 1'b1 && cyc < 20) begin
                        step();
                        cyc++;
                    end
                    ex = ia - ib - ic;
                    chk("sw4_latency", cyc, 4);
                    chk($sformatf("sw4_diff_%0d_%0d_%0d", ia, ib, ic),
                        {28'd0, diff4}, ex & 15);
                    chk($sformatf("sw4_bout_%0d_%0d_%0d", ia, ib, ic),
                        {31'd0, bout4}, (ia < ib + ic) ? 1 : 0);
                end
            end
        end
        step();
        chk("sw4_idle", {31'd0, busy4 | done4}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_serial_sub
`default_nettype wire
